fact_bus_if: RTL and testbench

Memory-mapped register interface for the factorial accelerator. It accepts a 4-bit operand and a start command from a simple word-addressed bus, then drives the factorial core (control unit plus datapath) with the operand and a single-cycle go pulse. It tracks busy state, latches the core's done, error and 32-bit result, and returns them on combinational reads. It sits between the system bus/SoC address decoder and the factorial core.

---
 rtl/fact_pkg.sv | 22 ++
 rtl/fact_en_reg.sv | 30 +++
 rtl/fact_status_reg.sv | 79 +++++++
 rtl/fact_bus_if.sv | 93 +++++++++
 tb/tb_fact_bus_if.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fact_pkg
// Description : Shared address map, status bit indices and operand limit for
//               the factorial accelerator bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
package fact_pkg;

    localparam logic [1:0] FACT_A_N      = 2'd0;
    localparam logic [1:0] FACT_A_GO     = 2'd1;
    localparam logic [1:0] FACT_A_STATUS = 2'd2;
    localparam logic [1:0] FACT_A_RESULT = 2'd3;

    localparam int FACT_ST_DONE = 0;
    localparam int FACT_ST_ERR  = 1;
    localparam int FACT_ST_BUSY = 2;

    localparam logic [3:0] FACT_N_MAX = 4'd12;

endpackage : fact_pkg
`default_nettype wire

// File: rtl/fact_en_reg.sv
`default_nettype none
// ============================================================================
// Module      : fact_en_reg
// Description : Load-enable register with synchronous active-high reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : fact_en_reg
`default_nettype wire

// File: rtl/fact_status_reg.sv
`default_nettype none
// ============================================================================
// Module      : fact_status_reg
// Description : Busy/done/err tracking for the factorial core and generation
//               of the single-cycle core_go pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_status_reg (
    input  logic clk,
    input  logic rst,
    input  logic i_go_req,
    input  logic i_core_done,
    input  logic i_core_err,
    output logic o_busy,
    output logic o_done,
    output logic o_err,
    output logic o_core_go,
    output logic o_complete
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic       r_done;
    logic       r_err;
    logic       r_core_go;
    logic       w_go_accept;
    logic       w_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A done strobe while running always wins; a GO is only seen from idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_go_req)    w_state_next = S_RUN;
            S_RUN:   if (i_core_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state == S_RUN);
        w_go_accept = (r_state == S_IDLE) && i_go_req;
        w_complete  = (r_state == S_RUN)  && i_core_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_core_go <= 1'b0;
        end else begin
            r_core_go <= w_go_accept;
            if (w_go_accept) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else if (w_complete) begin
                r_done <= 1'b1;
                r_err  <= i_core_err;
            end
        end
    end

    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_core_go  = r_core_go;
    assign o_complete = w_complete;

endmodule : fact_status_reg
`default_nettype wire

// File: rtl/fact_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : fact_bus_if
// Description : Word-addressed register interface driving the factorial core
//               with an operand and go pulse, latching status and result.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_bus_if
    import fact_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic [3:0]        core_n,
    output logic              core_go,
    input  logic              core_done,
    input  logic              core_err,
    input  logic [DATA_W-1:0] core_result
);

    logic [3:0]        w_n;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_result_d;
    logic [DATA_W-1:0] w_status;
    logic              w_busy;
    logic              w_done;
    logic              w_err;
    logic              w_complete;
    logic              w_go_req;
    logic              w_n_we;
    logic              w_unused;

    assign w_go_req   = we && (a == FACT_A_GO) && wd[0];
    assign w_n_we     = we && (a == FACT_A_N) && !w_busy;
    assign w_result_d = core_err ? '0 : core_result;
    assign w_unused   = &{1'b0, wd[DATA_W-1:4]};

    fact_status_reg u_status (
        .clk         (clk),
        .rst         (rst),
        .i_go_req    (w_go_req),
        .i_core_done (core_done),
        .i_core_err  (core_err),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_err       (w_err),
        .o_core_go   (core_go),
        .o_complete  (w_complete)
    );

    fact_en_reg #(.WIDTH(4)) u_n_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_n_we),
        .i_d  (wd[3:0]),
        .o_q  (w_n)
    );

    fact_en_reg #(.WIDTH(DATA_W)) u_result_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_complete),
        .i_d  (w_result_d),
        .o_q  (w_result)
    );

    assign core_n = w_n;

    always_comb begin
        w_status               = '0;
        w_status[FACT_ST_DONE] = w_done;
        w_status[FACT_ST_ERR]  = w_err;
        w_status[FACT_ST_BUSY] = w_busy;
    end

    always_comb begin
        rd = '0;
        case (a)
            FACT_A_N:      rd = {{(DATA_W-4){1'b0}}, w_n};
            FACT_A_GO:     rd = '0;
            FACT_A_STATUS: rd = w_status;
            FACT_A_RESULT: rd = w_result;
            default:       rd = '0;
        endcase
    end

endmodule : fact_bus_if
`default_nettype wire

// File: tb/tb_fact_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_fact_bus_if
// Description : Self-checking bench for fact_bus_if with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_bus_if;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        a = 2'd0;
    logic [DATA_W-1:0] wd = '0;
    logic [DATA_W-1:0] rd;
    logic [3:0]        core_n;
    logic              core_go;
    logic              core_done = 1'b0;
    logic              core_err = 1'b0;
    logic [DATA_W-1:0] core_result = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0]        m_n = '0;
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    logic              m_err = 1'b0;
    logic              m_go = 1'b0;
    logic [DATA_W-1:0] m_result = '0;

    always #5 clk = ~clk;

    fact_bus_if #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .a           (a),
        .wd          (wd),
        .rd          (rd),
        .core_n      (core_n),
        .core_go     (core_go),
        .core_done   (core_done),
        .core_err    (core_err),
        .core_result (core_result)
    );

    function automatic logic [DATA_W-1:0] fact(input int n);
        logic [DATA_W-1:0] p = 1;
        for (int i = 2; i <= n; i++) p = p * i;
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] model_rd(input logic [1:0] addr);
        case (addr)
            2'd0:    return {{(DATA_W-4){1'b0}}, m_n};
            2'd2:    return {{(DATA_W-3){1'b0}}, m_busy, m_err, m_done};
            2'd3:    return m_result;
            default: return '0;
        endcase
    endfunction

    // Advance one clock edge and apply the register-map rules to the model.
    task automatic tick();
        logic accept;
        logic n_ok;
        @(posedge clk);
        if (rst) begin
            m_n = '0; m_busy = 0; m_done = 0; m_err = 0; m_go = 0; m_result = '0;
        end else begin
            accept = we && (a == 2'd1) && wd[0] && !m_busy;
            n_ok   = we && (a == 2'd0) && !m_busy;
            if (n_ok) m_n = wd[3:0];
            if (core_done && m_busy) begin
                m_busy = 0; m_done = 1; m_err = core_err;
                m_result = core_err ? '0 : core_result;
            end else if (accept) begin
                m_busy = 1; m_done = 0; m_err = 0;
            end
            m_go = accept;
        end
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [DATA_W-1:0] data);
        we = 1; a = addr; wd = data;
        tick();
        we = 0; wd = '0;
    endtask

    task automatic read_addr(input logic [1:0] addr, output logic [DATA_W-1:0] data);
        a = addr;
        #1;
        data = rd;
    endtask

    task automatic done_strobe(input logic err, input logic [DATA_W-1:0] res);
        core_done = 1; core_err = err; core_result = res;
        tick();
        core_done = 0; core_err = 0; core_result = '0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] v;
        rst = 1;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            read_addr(2'(i), v);
            vectors++;
            if (v !== '0) begin
                miscompares++;
                $display("FAIL reset_rd addr=%0d got=%h exp=0", i, v);
            end
        end
        vectors++;
        if (core_go !== 1'b0 || core_n !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_core core_go=%b core_n=%0d exp 0/0", core_go, core_n);
        end
    endtask

    task automatic test_normal();
        logic [DATA_W-1:0] v;
        int go_count = 0;
        bus_write(2'd0, 32'd5);
        read_addr(2'd0, v);
        vectors++;
        if (v !== 32'd5) begin miscompares++; $display("FAIL normal_n got=%0d exp=5", v); end
        bus_write(2'd1, 32'd1);
        vectors++;
        if (core_go !== 1'b1) begin miscompares++; $display("FAIL normal_go_first got=%b exp=1", core_go); end
        if (core_go) go_count++;
        for (int i = 0; i < 9; i++) begin
            read_addr(2'd2, v);
            vectors++;
            if (v !== 32'h4 || core_n !== 4'd5) begin
                miscompares++;
                $display("FAIL normal_running status=%h core_n=%0d exp 4/5", v, core_n);
            end
            tick();
            if (core_go) go_count++;
        end
        vectors++;
        if (go_count != 1) begin miscompares++; $display("FAIL normal_go_pulses got=%0d exp=1", go_count); end
        done_strobe(1'b0, fact(int'(core_n)));
        read_addr(2'd2, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL normal_status got=%h exp=1", v); end
        read_addr(2'd3, v);
        vectors++;
        if (v !== 32'd120) begin miscompares++; $display("FAIL normal_result got=%0d exp=120", v); end
    endtask

    task automatic test_error();
        logic [DATA_W-1:0] v;
        bus_write(2'd0, 32'd13);
        bus_write(2'd1, 32'd1);
        tick(); tick(); tick();
        done_strobe(1'b1, 32'hDEAD_BEEF);
        read_addr(2'd2, v);
        vectors++;
        if (v !== 32'h3) begin miscompares++; $display("FAIL error_status got=%h exp=3", v); end
        read_addr(2'd3, v);
        vectors++;
        if (v !== 32'd0) begin miscompares++; $display("FAIL error_result got=%h exp=0", v); end
    endtask

    task automatic test_busy_protect();
        logic [DATA_W-1:0] v;
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd1);
        tick();
        bus_write(2'd0, 32'd7);
        read_addr(2'd0, v);
        vectors++;
        if (v !== 32'd3 || core_n !== 4'd3) begin
            miscompares++;
            $display("FAIL busy_n got=%0d core_n=%0d exp=3", v, core_n);
        end
        bus_write(2'd1, 32'd1);
        vectors++;
        if (core_go !== 1'b0) begin miscompares++; $display("FAIL busy_go got=%b exp=0", core_go); end
        tick();
        done_strobe(1'b0, fact(3));
        read_addr(2'd2, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL busy_status got=%h exp=1", v); end
        read_addr(2'd3, v);
        vectors++;
        if (v !== 32'd6) begin miscompares++; $display("FAIL busy_result got=%0d exp=6", v); end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] v;
        bus_write(2'd0, 32'd4);
        bus_write(2'd1, 32'd1);
        tick(); tick();
        we = 1; a = 2'd1; wd = 32'd1;
        done_strobe(1'b0, fact(4));
        we = 0; wd = '0;
        vectors++;
        if (core_go !== 1'b0) begin miscompares++; $display("FAIL collide_go got=%b exp=0", core_go); end
        read_addr(2'd2, v);
        vectors++;
        if (v !== 32'h1) begin miscompares++; $display("FAIL collide_status got=%h exp=1", v); end
        read_addr(2'd3, v);
        vectors++;
        if (v !== 32'd24) begin miscompares++; $display("FAIL collide_result got=%0d exp=24", v); end
        bus_write(2'd1, 32'd1);
        read_addr(2'd2, v);
        vectors++;
        if (core_go !== 1'b1 || v !== 32'h4) begin
            miscompares++;
            $display("FAIL collide_rego core_go=%b status=%h exp 1/4", core_go, v);
        end
        tick();
        done_strobe(1'b0, fact(4));
    endtask

    task automatic test_reset_mid_run();
        logic [DATA_W-1:0] v;
        bus_write(2'd0, 32'd6);
        bus_write(2'd1, 32'd1);
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            read_addr(2'(i), v);
            vectors++;
            if (v !== '0) begin
                miscompares++;
                $display("FAIL midrst_rd addr=%0d got=%h exp=0", i, v);
            end
        end
        done_strobe(1'b0, 32'd720);
        read_addr(2'd2, v);
        vectors++;
        if (v !== 32'd0) begin miscompares++; $display("FAIL midrst_spurious got=%h exp=0", v); end
        read_addr(2'd3, v);
        vectors++;
        if (v !== 32'd0) begin miscompares++; $display("FAIL midrst_spurious_res got=%h exp=0", v); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] v;
        logic [1:0]        ra;
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            we          = ($urandom_range(0, 2) != 0);
            a           = 2'($urandom_range(0, 3));
            wd          = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 15));
            core_done   = ($urandom_range(0, 5) == 0);
            core_err    = ($urandom_range(0, 3) == 0);
            core_result = DATA_W'($urandom);
            tick();
            rst = 0; we = 0; core_done = 0; core_err = 0;
            ra = 2'($urandom_range(0, 3));
            read_addr(ra, v);
            vectors++;
            if (v !== model_rd(ra) || core_go !== m_go || core_n !== m_n) begin
                miscompares++;
                $display("FAIL random[%0d] addr=%0d rd=%h exp=%h go=%b exp=%b n=%0d exp=%0d",
                         i, ra, v, model_rd(ra), core_go, m_go, core_n, m_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error();
        test_busy_protect();
        test_collision();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fact_bus_if
`default_nettype wire
